// File: rtl/nn_layer_sequencer.sv
// Two-layer fully-connected inference sequencer.
// Walks layer-1 (hidden neurons x inputs) then layer-2 (outputs x hidden)
// address spaces one beat per non-stalled cycle, and delays the per-beat
// MAC strobes by the SRAM read latency so they line up with read data.
module nn_layer_sequencer #(
  parameter int N_IN   = 784,
  parameter int N_HID  = 200,
  parameter int N_OUT  = 10,
  parameter int RD_LAT = 1
) (
  input  logic        clk_i,
  input  logic        reset_ni,
  input  logic        start_i,
  input  logic        stall_i,
  input  logic        hid_ready_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [17:0] w1_addr_o,
  output logic [9:0]  in_addr_o,
  output logic        rd1_en_o,
  output logic [11:0] w2_addr_o,
  output logic [7:0]  hid_addr_o,
  output logic        rd2_en_o,
  output logic        mac1_en_o,
  output logic        mac1_first_o,
  output logic        mac1_last_o,
  output logic        mac2_en_o,
  output logic        mac2_first_o,
  output logic        mac2_last_o
);

  typedef enum logic [2:0] {
    S_IDLE, S_L1_RUN, S_L1_DRAIN, S_WAIT_HID, S_L2_RUN, S_L2_DRAIN, S_FIN
  } state_e;

  typedef struct packed {
    logic en;
    logic first;
    logic last;
  } beat_t;

  localparam logic [9:0] I_LAST = 10'(N_IN - 1);
  localparam logic [7:0] H_LAST = 8'(N_HID - 1);
  localparam logic [7:0] K_LAST = 8'(N_HID - 1);
  localparam logic [3:0] O_LAST = 4'(N_OUT - 1);
  localparam logic [2:0] D_LAST = 3'(RD_LAT - 1);

  state_e state_q, state_d;

  logic [9:0]  i_q;
  logic [7:0]  h_q;
  logic [7:0]  k_q;
  logic [3:0]  o_q;
  logic [17:0] a1_q;   // flat h*N_IN+i, advanced by +1 per beat
  logic [11:0] a2_q;   // flat o*N_HID+k
  logic [2:0]  dcnt_q;

  beat_t iss1, iss2;
  beat_t [RD_LAT-1:0] p1_q, p2_q;

  logic l1_at_end, l2_at_end;
  assign l1_at_end = (i_q == I_LAST) && (h_q == H_LAST);
  assign l2_at_end = (k_q == K_LAST) && (o_q == O_LAST);

  // State register
  always_ff @(posedge clk_i) begin
    if (!reset_ni) state_q <= S_IDLE;
    else           state_q <= state_d;
  end

  // Next state, beat issue and status outputs
  always_comb begin
    state_d = state_q;
    iss1    = '0;
    iss2    = '0;
    busy_o  = 1'b0;
    done_o  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_i) state_d = S_L1_RUN;
      end
      S_L1_RUN: begin
        busy_o = 1'b1;
        if (!stall_i) begin
          iss1.en    = 1'b1;
          iss1.first = (i_q == '0);
          iss1.last  = (i_q == I_LAST);
          if (l1_at_end) state_d = S_L1_DRAIN;
        end
      end
      S_L1_DRAIN: begin
        busy_o = 1'b1;
        if (dcnt_q == D_LAST) state_d = S_WAIT_HID;
      end
      S_WAIT_HID: begin
        busy_o = 1'b1;
        if (hid_ready_i) state_d = S_L2_RUN;
      end
      S_L2_RUN: begin
        busy_o = 1'b1;
        if (!stall_i) begin
          iss2.en    = 1'b1;
          iss2.first = (k_q == '0);
          iss2.last  = (k_q == K_LAST);
          if (l2_at_end) state_d = S_L2_DRAIN;
        end
      end
      S_L2_DRAIN: begin
        busy_o = 1'b1;
        if (dcnt_q == D_LAST) state_d = S_FIN;
      end
      S_FIN: begin
        done_o  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Beat counters; the final beat of a layer leaves them parked so the
  // address outputs keep showing the last issued address.
  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      i_q    <= '0;
      h_q    <= '0;
      k_q    <= '0;
      o_q    <= '0;
      a1_q   <= '0;
      a2_q   <= '0;
      dcnt_q <= '0;
    end else begin
      if (state_q == S_IDLE && start_i) begin
        i_q  <= '0;
        h_q  <= '0;
        k_q  <= '0;
        o_q  <= '0;
        a1_q <= '0;
        a2_q <= '0;
      end
      if (state_q == S_L1_DRAIN || state_q == S_L2_DRAIN) dcnt_q <= dcnt_q + 3'd1;
      else                                                 dcnt_q <= '0;
      if (iss1.en && !l1_at_end) begin
        a1_q <= a1_q + 18'd1;
        if (i_q == I_LAST) begin
          i_q <= '0;
          h_q <= h_q + 8'd1;
        end else begin
          i_q <= i_q + 10'd1;
        end
      end
      if (iss2.en && !l2_at_end) begin
        a2_q <= a2_q + 12'd1;
        if (k_q == K_LAST) begin
          k_q <= '0;
          o_q <= o_q + 4'd1;
        end else begin
          k_q <= k_q + 8'd1;
        end
      end
    end
  end

  // MAC strobe delay lines; they shift every cycle so stalls become bubbles
  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      p1_q <= '0;
      p2_q <= '0;
    end else begin
      p1_q[0] <= iss1;
      p2_q[0] <= iss2;
      for (int j = 1; j < RD_LAT; j++) begin
        p1_q[j] <= p1_q[j-1];
        p2_q[j] <= p2_q[j-1];
      end
    end
  end

  assign w1_addr_o    = a1_q;
  assign in_addr_o    = i_q;
  assign rd1_en_o     = iss1.en;
  assign w2_addr_o    = a2_q;
  assign hid_addr_o   = k_q;
  assign rd2_en_o     = iss2.en;
  assign mac1_en_o    = p1_q[RD_LAT-1].en;
  assign mac1_first_o = p1_q[RD_LAT-1].first;
  assign mac1_last_o  = p1_q[RD_LAT-1].last;
  assign mac2_en_o    = p2_q[RD_LAT-1].en;
  assign mac2_first_o = p2_q[RD_LAT-1].first;
  assign mac2_last_o  = p2_q[RD_LAT-1].last;

endmodule

// File: tb/tb_nn_layer_sequencer.sv
// Bench for nn_layer_sequencer: two instances (read latency 1 and 3) share
// stimulus; a beat-index model predicts every output each cycle, and
// per-run tallies are pinned against hand-computed numbers.
module tb_nn_layer_sequencer;
  localparam int NI = 4, NH = 3, NO = 2;
  localparam int N1 = NI * NH, N2 = NH * NO;

  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, stall = 1'b0, hid = 1'b0;
  logic busy[2], done[2], rd1[2], rd2[2];
  logic m1e[2], m1f[2], m1l[2], m2e[2], m2f[2], m2l[2];
  logic [17:0] w1[2];
  logic [9:0]  ia[2];
  logic [11:0] w2[2];
  logic [7:0]  ha[2];

  always #5 clk = ~clk;

  nn_layer_sequencer #(.N_IN(NI), .N_HID(NH), .N_OUT(NO), .RD_LAT(1)) dut0 (
    .clk_i(clk), .reset_ni(rst_n), .start_i(start), .stall_i(stall), .hid_ready_i(hid),
    .busy_o(busy[0]), .done_o(done[0]), .w1_addr_o(w1[0]), .in_addr_o(ia[0]),
    .rd1_en_o(rd1[0]), .w2_addr_o(w2[0]), .hid_addr_o(ha[0]), .rd2_en_o(rd2[0]),
    .mac1_en_o(m1e[0]), .mac1_first_o(m1f[0]), .mac1_last_o(m1l[0]),
    .mac2_en_o(m2e[0]), .mac2_first_o(m2f[0]), .mac2_last_o(m2l[0]));

  nn_layer_sequencer #(.N_IN(NI), .N_HID(NH), .N_OUT(NO), .RD_LAT(3)) dut1 (
    .clk_i(clk), .reset_ni(rst_n), .start_i(start), .stall_i(stall), .hid_ready_i(hid),
    .busy_o(busy[1]), .done_o(done[1]), .w1_addr_o(w1[1]), .in_addr_o(ia[1]),
    .rd1_en_o(rd1[1]), .w2_addr_o(w2[1]), .hid_addr_o(ha[1]), .rd2_en_o(rd2[1]),
    .mac1_en_o(m1e[1]), .mac1_first_o(m1f[1]), .mac1_last_o(m1l[1]),
    .mac2_en_o(m2e[1]), .mac2_first_o(m2f[1]), .mac2_last_o(m2l[1]));

  // ---------------- model: phase + beat indices + strobe history
  // ph: 0 idle, 1 layer-1 beats, 2 drain, 3 wait hidden, 4 layer-2 beats, 5 drain, 6 finish
  int ph[2] = '{0, 0}, b1[2] = '{0, 0}, b2[2] = '{0, 0}, dc[2] = '{0, 0};
  logic [2:0] hist1[2][8], hist2[2][8];   // {en,first,last} issued j+1 cycles ago

  function automatic int lat(input int x);
    return (x == 0) ? 1 : 3;
  endfunction

  function automatic logic [2:0] iss1(input int x);
    if (ph[x] == 1 && !stall) return {1'b1, (b1[x] % NI) == 0, (b1[x] % NI) == NI - 1};
    return 3'b000;
  endfunction

  function automatic logic [2:0] iss2(input int x);
    if (ph[x] == 4 && !stall) return {1'b1, (b2[x] % NH) == 0, (b2[x] % NH) == NH - 1};
    return 3'b000;
  endfunction

  always @(posedge clk) begin
    for (int x = 0; x < 2; x++) begin
      if (!rst_n) begin
        ph[x] <= 0; b1[x] <= 0; b2[x] <= 0; dc[x] <= 0;
        for (int j = 0; j < 8; j++) begin
          hist1[x][j] <= 3'b000;
          hist2[x][j] <= 3'b000;
        end
      end else begin
        hist1[x][0] <= iss1(x);
        hist2[x][0] <= iss2(x);
        for (int j = 1; j < 8; j++) begin
          hist1[x][j] <= hist1[x][j-1];
          hist2[x][j] <= hist2[x][j-1];
        end
        case (ph[x])
          0: if (start) begin ph[x] <= 1; b1[x] <= 0; b2[x] <= 0; end
          1: if (!stall) begin
               b1[x] <= b1[x] + 1;
               if (b1[x] + 1 == N1) begin ph[x] <= 2; dc[x] <= 0; end
             end
          2: begin dc[x] <= dc[x] + 1; if (dc[x] + 1 == lat(x)) ph[x] <= 3; end
          3: if (hid) ph[x] <= 4;
          4: if (!stall) begin
               b2[x] <= b2[x] + 1;
               if (b2[x] + 1 == N2) begin ph[x] <= 5; dc[x] <= 0; end
             end
          5: begin dc[x] <= dc[x] + 1; if (dc[x] + 1 == lat(x)) ph[x] <= 6; end
          default: ph[x] <= 0;
        endcase
      end
    end
  end

  // ---------------- checking
  int checks = 0, failures = 0;
  int n_rd1[2], n_rd2[2], n_done[2], n_busy[2], n_m1e[2], done_cyc[2], first_rd2[2], last_m1l[2];
  int w1q[$], iaq[$], w2q[$], haq[$], m1fq[$], m1lq[$];
  int w1_stall, rd1_stall, snap_addr, snap_ctl;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s got=%0d want=%0d t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic sample(input int c);
    for (int x = 0; x < 2; x++) begin
      logic [2:0] e1, e2;
      int ew1, ew2;
      e1  = iss1(x);
      e2  = iss2(x);
      ew1 = (b1[x] >= N1) ? N1 - 1 : b1[x];
      ew2 = (b2[x] >= N2) ? N2 - 1 : b2[x];
      chk($sformatf("busy[%0d]", x), int'(busy[x]), int'(ph[x] >= 1 && ph[x] <= 5));
      chk($sformatf("done[%0d]", x), int'(done[x]), int'(ph[x] == 6));
      chk($sformatf("rd1_en[%0d]", x), int'(rd1[x]), int'(e1[2]));
      chk($sformatf("w1_addr[%0d]", x), int'(w1[x]), ew1);
      chk($sformatf("in_addr[%0d]", x), int'(ia[x]), ew1 % NI);
      chk($sformatf("rd2_en[%0d]", x), int'(rd2[x]), int'(e2[2]));
      chk($sformatf("w2_addr[%0d]", x), int'(w2[x]), ew2);
      chk($sformatf("hid_addr[%0d]", x), int'(ha[x]), ew2 % NH);
      chk($sformatf("mac1[%0d]", x), int'({m1e[x], m1f[x], m1l[x]}), int'(hist1[x][lat(x)-1]));
      chk($sformatf("mac2[%0d]", x), int'({m2e[x], m2f[x], m2l[x]}), int'(hist2[x][lat(x)-1]));
      if (c > 0) begin
        if (rd1[x])  n_rd1[x]++;
        if (rd2[x])  n_rd2[x]++;
        if (busy[x]) n_busy[x]++;
        if (m1e[x])  n_m1e[x]++;
        if (done[x]) begin n_done[x]++; done_cyc[x] = c; end
        if (rd2[x] && first_rd2[x] < 0) first_rd2[x] = c;
        if (m1l[x]) last_m1l[x] = c;
        if (x == 0) begin
          if (rd1[0]) begin w1q.push_back(int'(w1[0])); iaq.push_back(int'(ia[0])); end
          if (rd2[0]) begin w2q.push_back(int'(w2[0])); haq.push_back(int'(ha[0])); end
          if (m1f[0]) m1fq.push_back(c);
          if (m1l[0]) m1lq.push_back(c);
        end
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk); sample(0);
      @(posedge clk); #1;
    end
  endtask

  // One start pulse then maxc cycles of scheduled stall/hid_ready/start/reset
  task automatic run(input int stall_at, input int stall_len, input int hid_at,
                     input int p0, input int p1, input int rst_at, input int maxc);
    for (int x = 0; x < 2; x++) begin
      n_rd1[x] = 0; n_rd2[x] = 0; n_done[x] = 0; n_busy[x] = 0; n_m1e[x] = 0;
      done_cyc[x] = -1; first_rd2[x] = -1; last_m1l[x] = -1;
    end
    w1q.delete(); iaq.delete(); w2q.delete(); haq.delete(); m1fq.delete(); m1lq.delete();
    start = 1'b1; stall = 1'b0; hid = (hid_at <= 0);
    @(negedge clk); sample(0);
    @(posedge clk); #1;
    for (int c = 1; c <= maxc; c++) begin
      start = (c == p0) || (c == p1);
      stall = (c >= stall_at) && (c < stall_at + stall_len);
      hid   = (c >= hid_at);
      rst_n = !(rst_at > 0 && c == rst_at);
      @(negedge clk);
      sample(c);
      if (c == stall_at) begin w1_stall = int'(w1[0]); rd1_stall = int'(rd1[0]); end
      if (rst_at > 0 && c == rst_at + 1) begin
        snap_addr = int'(w1[0]) + int'(w1[1]) + int'(ia[0]) + int'(ia[1]);
        snap_ctl  = int'(busy[0]) + int'(busy[1]) + int'(rd1[0]) + int'(rd1[1]) +
                    int'(m1e[0]) + int'(m1e[1]) + int'(done[0]) + int'(done[1]);
      end
      @(posedge clk); #1;
    end
    start = 1'b0; stall = 1'b0; rst_n = 1'b1;
  endtask

  task automatic check_plain(input string t);
    int exp_ia[12] = '{0, 1, 2, 3, 0, 1, 2, 3, 0, 1, 2, 3};
    int exp_ha[6]  = '{0, 1, 2, 0, 1, 2};
    chk({t, ".rd1_cnt0"}, n_rd1[0], 12);
    chk({t, ".rd1_cnt1"}, n_rd1[1], 12);
    chk({t, ".rd2_cnt0"}, n_rd2[0], 6);
    chk({t, ".rd2_cnt1"}, n_rd2[1], 6);
    chk({t, ".done_cnt0"}, n_done[0], 1);
    chk({t, ".done_cnt1"}, n_done[1], 1);
    chk({t, ".done_cyc0"}, done_cyc[0], 22);
    chk({t, ".done_cyc1"}, done_cyc[1], 26);
    chk({t, ".busy_cyc0"}, n_busy[0], 21);
    chk({t, ".busy_cyc1"}, n_busy[1], 25);
    chk({t, ".first_rd2_0"}, first_rd2[0], 15);
    chk({t, ".first_rd2_1"}, first_rd2[1], 17);
    chk({t, ".last_m1l_1"}, last_m1l[1], 15);
    chk({t, ".w1_len"}, w1q.size(), 12);
    for (int j = 0; j < 12 && j < w1q.size(); j++) begin
      chk($sformatf("%s.w1_seq[%0d]", t, j), w1q[j], j);
      chk($sformatf("%s.in_seq[%0d]", t, j), iaq[j], exp_ia[j]);
    end
    chk({t, ".w2_len"}, w2q.size(), 6);
    for (int j = 0; j < 6 && j < w2q.size(); j++) begin
      chk($sformatf("%s.w2_seq[%0d]", t, j), w2q[j], j);
      chk($sformatf("%s.hid_seq[%0d]", t, j), haq[j], exp_ha[j]);
    end
    chk({t, ".m1f_len"}, m1fq.size(), 3);
    chk({t, ".m1l_len"}, m1lq.size(), 3);
    for (int j = 0; j < 3 && j < m1fq.size() && j < m1lq.size(); j++) begin
      chk($sformatf("%s.m1f_cyc[%0d]", t, j), m1fq[j], 2 + 4 * j);
      chk($sformatf("%s.m1l_cyc[%0d]", t, j), m1lq[j], 5 + 4 * j);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    sample(0);
    chk("rst.w1", int'(w1[0]) + int'(w1[1]), 0);
    chk("rst.ctl", int'(busy[0]) + int'(busy[1]) + int'(rd1[0]) + int'(rd2[1]) +
                   int'(m1e[0]) + int'(m2e[1]) + int'(done[0]) + int'(done[1]), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(2);

    // plain run, hidden buffer already ready
    run(0, 0, 0, 0, 0, 0, 30);
    check_plain("A");
    idle(2);

    // two-cycle stall when beat 5 is due
    run(6, 2, 0, 0, 0, 0, 32);
    chk("B.w1_held", w1_stall, 5);
    chk("B.rd1_held", rd1_stall, 0);
    chk("B.rd1_cnt0", n_rd1[0], 12);
    chk("B.rd1_cnt1", n_rd1[1], 12);
    chk("B.m1e_cnt0", n_m1e[0], 12);
    chk("B.m1e_cnt1", n_m1e[1], 12);
    chk("B.busy_cyc0", n_busy[0], 23);
    chk("B.busy_cyc1", n_busy[1], 27);
    chk("B.done_cyc0", done_cyc[0], 24);
    chk("B.done_cyc1", done_cyc[1], 28);
    idle(2);

    // hidden buffer becomes ready late
    run(0, 0, 22, 0, 0, 0, 35);
    chk("C.first_rd2_0", first_rd2[0], 23);
    chk("C.first_rd2_1", first_rd2[1], 23);
    chk("C.rd2_cnt0", n_rd2[0], 6);
    chk("C.done_cyc0", done_cyc[0], 30);
    chk("C.done_cyc1", done_cyc[1], 32);
    idle(2);

    // reset while w1_addr shows 6, then a fresh run
    run(0, 0, 0, 0, 0, 7, 12);
    chk("D.addr_zero", snap_addr, 0);
    chk("D.ctl_zero", snap_ctl, 0);
    chk("D.no_done0", n_done[0], 0);
    chk("D.no_done1", n_done[1], 0);
    idle(2);
    run(0, 0, 0, 0, 0, 0, 30);
    check_plain("D2");
    idle(2);

    // start pulses while busy and while in the finish cycle
    run(0, 0, 0, 5, 22, 0, 30);
    chk("E.done_cnt0", n_done[0], 1);
    chk("E.done_cnt1", n_done[1], 1);
    chk("E.busy_cyc0", n_busy[0], 21);
    chk("E.rd1_cnt0", n_rd1[0], 12);
    chk("E.done_cyc1", done_cyc[1], 26);
    idle(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/nn_layer_sequencer.md
Name: nn_layer_sequencer

Overview:
- Sequences the two-layer fully-connected inference datapath: generates the layer-1 weight/input SRAM addresses and the layer-2 weight/hidden-buffer addresses, plus MAC control strobes aligned to SRAM read latency.
- Sits between the top-level control and the SRAM_WEIGHT1/2, SRAM_INPUTn, MAC and sigmoid blocks.
- Replaces bench-driven address/start generation.
- One `start` runs a full image batch: layer 1 over all hidden neurons, wait for the hidden buffer, then layer 2 over all outputs.

Parameters:
- N_IN, 784, inputs per hidden neuron
- N_HID, 200, hidden neurons
- N_OUT, 10, output neurons
- RD_LAT, 1, SRAM read latency in cycles (1..4); MAC strobes delayed by this amount

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-low reset
- start  in  1  run request; sampled only in IDLE
- stall  in  1  freeze address issue this cycle
- hid_ready  in  1  level: sigmoid-1 outputs written to hidden buffer
- busy  out  1  high from start acceptance until done
- done  out  1  one-cycle pulse at end of run
- w1_addr  out  18  layer-1 weight address = h*N_IN+i
- in_addr  out  10  input SRAM address = i
- rd1_en  out  1  w1_addr/in_addr valid this cycle
- w2_addr  out  12  layer-2 weight address = o*N_HID+k
- hid_addr  out  8  hidden buffer address = k
- rd2_en  out  1  w2_addr/hid_addr valid this cycle
- mac1_en, mac1_first, mac1_last  out  1 each  layer-1 MAC beat, clear-accumulator, final-term
- mac2_en, mac2_first, mac2_last  out  1 each  layer-2 equivalents

Behaviour:
- Reset (reset=0 at a clock edge):
  - all outputs 0; state IDLE; counters i, h, k, o cleared; strobe delay pipelines flushed.
  - Applies from any state, including mid-run; no done pulse.
- States: IDLE -> L1_RUN -> L1_DRAIN -> WAIT_HID -> L2_RUN -> L2_DRAIN -> FIN -> IDLE.
- IDLE: start=1 -> L1_RUN, busy=1 next cycle. start in any other state is ignored.
- L1_RUN, each edge with stall=0 issues one beat:
  - rd1_en=1, w1_addr=h*N_IN+i, in_addr=i.
  - first beat of neuron when i==0; last when i==N_IN-1.
  - i increments; at N_IN-1 it wraps to 0 and h increments.
  - After beat (h=N_HID-1, i=N_IN-1) -> L1_DRAIN.
- L1_RUN with stall=1: rd1_en=0, addresses hold, counters hold.
- Beat order is strictly sequential; addresses never skip or repeat except while held under stall (held with rd1_en=0).
- MAC alignment: mac1_en/first/last equal the issue-cycle rd1_en/first/last flags delayed exactly RD_LAT cycles.
  - The pipeline keeps shifting during stall, so bubbles appear as mac1_en=0.
- L1_DRAIN: rd1_en=0; wait RD_LAT cycles until the last mac1_last has emerged, then -> WAIT_HID.
- WAIT_HID: hold until hid_ready=1. If hid_ready is already 1 on entry, -> L2_RUN next edge.
- L2_RUN: identical to L1_RUN using k over N_HID, o over N_OUT, w2_addr=o*N_HID+k, hid_addr=k, rd2_en, mac2_* strobes. stall honoured the same way.
- L2_DRAIN: RD_LAT cycles -> FIN.
- FIN: done=1 for one cycle, busy=0 in the same cycle, -> IDLE.
  - start asserted in FIN is ignored; the next run starts from IDLE.
- Unused address outputs hold their last value when their enable is 0. Reset clears them to 0.
- Beat counts: exactly N_IN*N_HID rd1_en cycles and N_HID*N_OUT rd2_en cycles per run.
- Layer-1 and layer-2 strobes never overlap.
- Address arithmetic: counters are saturating-free and wrap only as described. w1_addr max 156799 fits 18 bits; w2_addr max 1999 fits 12 bits.

Test Plan:
- Small config (N_IN=4, N_HID=3, N_OUT=2, RD_LAT=1), start pulse, hid_ready tied 1 -> w1_addr 0..11 consecutive with in_addr cycling 0,1,2,3; mac1_first on beats 0,4,8 and mac1_last on beats 3,7,11, each one cycle after issue; then w2_addr 0..5, hid_addr 0,1,2,0,1,2; done one cycle; busy high for the whole run.
- Same config, stall=1 for 2 cycles at beat 5 -> w1_addr holds at 5 with rd1_en=0, two mac1_en=0 bubbles, total rd1_en count still 12.
- hid_ready=0 until 7 cycles after L1_DRAIN -> no rd2_en while waiting; first w2_addr=0 on the edge after hid_ready rises.
- RD_LAT=3 -> mac1_last for beat 11 appears 3 cycles after issue; rd2_en first rises only after that.
- reset=0 asserted mid-L1 at w1_addr=6 -> all outputs 0 next edge, no done; a new start restarts from w1_addr=0.
- start pulsed during busy and during FIN -> ignored; exactly one done per accepted start.
